// File: rtl/entrada_operandos_pkg.sv
// Shared types and default timing for the entrada_operandos operand-entry controller.
package entrada_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    SHOW   = 2'd3
  } fase_t;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int DONE_TIMEOUT_DEF    = 64;

endpackage

// File: rtl/entrada_operandos_if.sv
// Operand-entry bus: switches/key/done in, operands and divider handshake out.
interface entrada_operandos_if #(parameter int WIDTH = 4);
  import entrada_pkg::*;

  logic [WIDTH-1:0] Sw;
  logic             Key;
  logic             Done;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Start;
  logic             Strobe;
  logic             Busy_err;
  fase_t            Fase;

  modport master (
    output Sw, Key, Done,
    input  A, B, Start, Strobe, Busy_err, Fase
  );

  modport slave (
    input  Sw, Key, Done,
    output A, B, Start, Strobe, Busy_err, Fase
  );

endinterface

// File: rtl/entrada_operandos_debounce_tecla.sv
// Pushbutton conditioner: two-flop synchronizer, stability counter and a
// one-cycle press pulse on the debounced falling edge (Key is active-low).
module debounce_tecla #(
  parameter int DEBOUNCE_CYCLES = entrada_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Key,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          keyDeb;
  logic [CW-1:0] stableCnt;

  // Everything resets to the released level so power-up never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      keyDeb    <= 1'b1;
      stableCnt <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= Key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == keyDeb) begin
        stableCnt <= '0;
      end else if (stableCnt == LAST) begin
        keyDeb    <= sync2;
        stableCnt <= '0;
        press     <= ~sync2;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/entrada_operandos.sv
// Operand entry and divider sequencing for the 4-bit divider display path.
// Optional build macro DIVZERO_CHECK_EN: a zero divisor skips the division and flags Busy_err.
module entrada_operandos
  import entrada_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DONE_TIMEOUT    = DONE_TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  entrada_operandos_if.slave bus
);

  localparam int WCW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(DONE_TIMEOUT - 1);

  logic             press;
  logic             divZero;
  fase_t            fase;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             startR;
  logic             strobeR;
  logic             errR;
  logic [WCW-1:0]   waitCnt;

  debounce_tecla #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .Key  (bus.Key),
    .press(press)
  );

`ifdef DIVZERO_CHECK_EN
  assign divZero = (bus.Sw == '0);
`else
  assign divZero = 1'b0;
`endif

  // startR doubles as the "first RUN cycle" marker, so a Done left high
  // from before the request cannot end the division early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fase    <= LOAD_A;
      opA     <= '0;
      opB     <= '0;
      startR  <= 1'b0;
      strobeR <= 1'b0;
      errR    <= 1'b0;
      waitCnt <= '0;
    end else begin
      startR <= 1'b0;
      case (fase)
        LOAD_A: begin
          if (press) begin
            opA  <= bus.Sw;
            errR <= 1'b0;
            fase <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            opB <= bus.Sw;
            if (divZero) begin
              errR <= 1'b1;
              fase <= SHOW;
            end else begin
              startR  <= 1'b1;
              strobeR <= 1'b1;
              waitCnt <= '0;
              fase    <= RUN;
            end
          end
        end
        RUN: begin
          waitCnt <= waitCnt + 1'b1;
          if (bus.Done && !startR) begin
            strobeR <= 1'b0;
            fase    <= SHOW;
          end else if (waitCnt == WLAST) begin
            errR    <= 1'b1;
            strobeR <= 1'b0;
            fase    <= SHOW;
          end
        end
        SHOW: begin
          if (press) begin
            errR <= 1'b0;
            fase <= LOAD_A;
          end
        end
        default: fase <= LOAD_A;
      endcase
    end
  end

  assign bus.A        = opA;
  assign bus.B        = opB;
  assign bus.Start    = startR;
  assign bus.Strobe   = strobeR;
  assign bus.Busy_err = errR;
  assign bus.Fase     = fase;

endmodule

// File: doc/entrada_operandos.md
Name: entrada_operandos

Overview:
- Input-side controller for the pratica03 4-bit divider, the write/capture end of the display interface.
- Reads operands A and B from four slide switches, one at a time, on debounced pushbutton presses.
- Issues a one-cycle Start to the divider and drives Strobe high while the division is in flight; the output stage blanks its displays when Strobe is high.
- Returns to display mode when the divider reports Done.

Parameters:
- WIDTH, 4, operand width in bits.
- DEBOUNCE_CYCLES, 500000, clock cycles Key must hold a stable level before it is accepted (10 ms at 50 MHz).
- DONE_TIMEOUT, 64, maximum cycles to wait for Done before aborting.

Ports:
- clk  input  1  system clock; all flops rise on it.
- rst_n  input  1  asynchronous active-low reset.
- Sw  input  WIDTH  raw switch value; asynchronous, read only on an accepted press.
- Key  input  1  raw pushbutton, active-low; bounces.
- Done  input  1  divider completion; level or pulse, sampled on clk.
- A  output  WIDTH  registered dividend.
- B  output  WIDTH  registered divisor.
- Start  output  1  one-cycle pulse requesting a division.
- Strobe  output  1  high while division is busy; low means displays are valid.
- Busy_err  output  1  sticky flag: Done timeout occurred.
- Fase  output  2  current state encoding, for LEDs.

Behaviour:
- Reset, asynchronous on rst_n low:
  - A=0, B=0, Start=0, Strobe=0, Busy_err=0, Fase=LOAD_A.
  - Debounce counter and synchronizer cleared; the synchronizer resets to 1 (key released).
- Key path:
  - Two-flop synchronizer, then a counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of equal synchronized value that differs from the current debounced level.
  - press = one-cycle pulse on the debounced 1->0 transition. Release generates nothing.
- FSM states (Fase encoding): LOAD_A=0, LOAD_B=1, RUN=2, SHOW=3.
  - LOAD_A: on press, A<=Sw, clear Busy_err, go to LOAD_B.
  - LOAD_B: on press, B<=Sw, Start=1 in the next cycle, go to RUN.
  - RUN: Strobe=1. Done sampled high goes to SHOW. A wait counter reaching DONE_TIMEOUT sets Busy_err=1 and goes to SHOW. Presses are ignored.
  - SHOW: Strobe=0. On press, go to LOAD_A; A and B hold until overwritten.
- Start timing:
  - Asserted exactly one cycle, in the first RUN cycle, registered.
  - A and B are stable from the cycle Start rises until leaving RUN.
- Done handling:
  - Done already high on RUN entry is not accepted in the Start cycle; it is accepted from the second RUN cycle.
  - Done outside RUN is ignored.
- Simultaneous events: a press and the timeout in the same cycle resolve to the timeout; the press is lost.
- Sw is captured as-is; all 16 values are legal.
- Strobe is low in LOAD_A, LOAD_B and SHOW, so operands display live during entry.

Optional Feature:
- Macro: DIVZERO_CHECK_EN.
- Defined: in LOAD_B, a press with Sw==0 still captures B=0, but no Start is issued. The FSM goes directly to SHOW with Busy_err=1; Strobe stays 0.
- Undefined: B=0 is passed to the divider like any other value.

Decomposition:
- Package entrada_pkg holds:
  - the state typedef (2-bit enum LOAD_A/LOAD_B/RUN/SHOW);
  - defaults for DEBOUNCE_CYCLES and DONE_TIMEOUT.
- Sub-module debounce_tecla contains the synchronizer, the stability counter, and the press-pulse generator. Parameter DEBOUNCE_CYCLES; ports clk, rst_n, Key, press.

Test Plan (DEBOUNCE_CYCLES=4, DONE_TIMEOUT=8 in sim):
- Reset: hold rst_n=0 mid-operation -> all outputs reset immediately without a clock edge; Fase=0.
- Bouncy press: Key toggles every 2 cycles for 10 cycles, then stays low -> exactly one press; A captures Sw=4'd9; Fase=1.
- Full division: A=9, then Sw=4'd2 pressed -> B=2; Start high for exactly 1 cycle; Strobe=1. Done pulsed 3 cycles later -> Strobe=0, Fase=3.
- Timeout: Done never asserted -> after 8 RUN cycles Busy_err=1, Strobe=0, Fase=3. The next press clears Busy_err and returns to LOAD_A.
- Divide by zero with DIVZERO_CHECK_EN: B press with Sw=0 -> no Start pulse, Busy_err=1, Fase=3. Without the macro -> Start pulses and Fase=2.
- Press during RUN: a Key press while Strobe=1 -> ignored; A and B unchanged; the FSM leaves RUN only on Done.
